bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_updown_counter.sv | 109 ++++++++++
 tb/tb_bcd_updown_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, wrap or saturate at the boundaries.
// Latency: one clk edge from inputs to count/tc/err. No backpressure; a step is taken on every enabled edge.
module bcd_updown_counter #(
    parameter int DIGITS = 3,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  err
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                tc_q, tc_d;
    logic                err_q, err_d;

    logic [4*DIGITS-1:0] step_cnt;
    logic [3:0]          dig;
    logic [3:0]          nxt;
    logic                carry;
    logic                load_bad;
    logic                all_nine;
    logic                all_zero;
    logic                boundary;

    always_comb begin
        count_d  = count_q;
        tc_d     = 1'b0;
        err_d    = 1'b0;
        step_cnt = count_q;
        dig      = 4'd0;
        nxt      = 4'd0;
        carry    = 1'b1;
        load_bad = 1'b0;
        all_nine = 1'b1;
        all_zero = 1'b1;
        boundary = 1'b0;

        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[i*4 +: 4] > 4'd9) load_bad = 1'b1;
            if (count_q[i*4 +: 4] != 4'd9) all_nine = 1'b0;
            if (count_q[i*4 +: 4] != 4'd0) all_zero = 1'b0;
        end

        // Ripple the carry/borrow through the digits; digits past the first non-rolling one stay put.
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[i*4 +: 4];
            nxt = dig;
            if (carry) begin
                if (up) begin
                    if (dig == 4'd9) begin
                        nxt = 4'd0;
                    end else begin
                        nxt   = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        nxt = 4'd9;
                    end else begin
                        nxt   = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            step_cnt[i*4 +: 4] = nxt;
        end

        boundary = up ? all_nine : all_zero;

        if (load) begin
            if (load_bad) begin
                err_d = 1'b1;
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (boundary) begin
                tc_d    = 1'b1;
                count_d = (WRAP != 0) ? step_cnt : count_q;
            end else begin
                count_d = step_cnt;
            end
        end
    end

    // Deassertion is expected away from the clk edge; the first edge after release counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: three counter variants (3-digit wrap, 3-digit saturate, 1-digit wrap) share one stimulus stream.
module tb_bcd_updown_counter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        load;
    logic [11:0] load_val;

    logic [11:0] count_w, count_s;
    logic [3:0]  count_1;
    logic        tc_w, tc_s, tc_1;
    logic        err_w, err_s, err_1;

    bcd_updown_counter #(.DIGITS(3), .WRAP(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .err(err_w));

    bcd_updown_counter #(.DIGITS(3), .WRAP(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_s), .tc(tc_s), .err(err_s));

    bcd_updown_counter #(.DIGITS(1), .WRAP(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]), .count(count_1), .tc(tc_1), .err(err_1));

    typedef struct {
        int          dut;
        logic [31:0] cnt;
        logic        tc;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt[3];
    int m_dig[3];
    int m_wrap[3];
    int tc_hits;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2int(input logic [31:0] v, input int d);
        int r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input int v, input int d);
        logic [31:0] r = '0;
        int          t = v;
        for (int i = 0; i < d; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [31:0] v, input int d);
        for (int i = 0; i < d; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one cycle of stimulus, predict each variant numerically, then compare after the edge.
    task automatic step(input logic e, input logic u, input logic l, input logic [11:0] lv);
        exp_t x;
        exp_t p;
        logic [31:0] lv32;
        logic [31:0] got_c;
        logic        got_t, got_e;
        int          mx;
        en = e; up = u; load = l; load_val = lv;
        for (int k = 0; k < 3; k++) begin
            mx = 1;
            for (int i = 0; i < m_dig[k]; i++) mx = mx * 10;
            mx = mx - 1;
            lv32 = '0;
            for (int i = 0; i < m_dig[k]; i++) lv32[i*4 +: 4] = lv[i*4 +: 4];
            x.dut = k; x.tc = 1'b0; x.err = 1'b0;
            if (l) begin
                if (bcd_ok(lv32, m_dig[k])) m_cnt[k] = bcd2int(lv32, m_dig[k]);
                else x.err = 1'b1;
            end else if (e) begin
                if (u) begin
                    if (m_cnt[k] == mx) begin
                        x.tc = 1'b1;
                        m_cnt[k] = (m_wrap[k] != 0) ? 0 : mx;
                    end else m_cnt[k] = m_cnt[k] + 1;
                end else begin
                    if (m_cnt[k] == 0) begin
                        x.tc = 1'b1;
                        m_cnt[k] = (m_wrap[k] != 0) ? mx : 0;
                    end else m_cnt[k] = m_cnt[k] - 1;
                end
            end
            x.cnt = int2bcd(m_cnt[k], m_dig[k]);
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            case (p.dut)
                0:       begin got_c = 32'(count_w); got_t = tc_w; got_e = err_w; end
                1:       begin got_c = 32'(count_s); got_t = tc_s; got_e = err_s; end
                default: begin got_c = 32'(count_1); got_t = tc_1; got_e = err_1; end
            endcase
            check($sformatf("count[dut%0d]", p.dut), got_c, p.cnt);
            check($sformatf("tc[dut%0d]", p.dut), 32'(got_t), 32'(p.tc));
            check($sformatf("err[dut%0d]", p.dut), 32'(got_e), 32'(p.err));
        end
        if (tc_w) tc_hits++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cnt_w"}, 32'(count_w), 32'h0);
        check({tag, "_cnt_s"}, 32'(count_s), 32'h0);
        check({tag, "_cnt_1"}, 32'(count_1), 32'h0);
        check({tag, "_tc"},  32'({tc_w, tc_s, tc_1}),  32'h0);
        check({tag, "_err"}, 32'({err_w, err_s, err_1}), 32'h0);
    endtask

    initial begin
        m_dig[0] = 3; m_dig[1] = 3; m_dig[2] = 1;
        m_wrap[0] = 1; m_wrap[1] = 0; m_wrap[2] = 1;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_state("por");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full 000..999..000 sweep
        tc_hits = 0;
        for (int n = 0; n < 1000; n++) step(1'b1, 1'b1, 1'b0, 12'h0);
        check("sweep_tc_once", 32'(tc_hits), 32'd1);

        // Borrow through two digits
        step(1'b0, 1'b0, 1'b1, 12'h100);
        step(1'b1, 1'b0, 1'b0, 12'h0);
        step(1'b1, 1'b0, 1'b0, 12'h0);

        // Upper boundary, wrap vs saturate with repeated attempts
        step(1'b0, 1'b1, 1'b1, 12'h998);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 12'h0);

        // Invalid load holds and flags; valid load beats enable
        step(1'b0, 1'b1, 1'b1, 12'h1A5);
        step(1'b1, 1'b1, 1'b1, 12'h123);

        // Idle cycles hold regardless of direction
        step(1'b0, 1'b0, 1'b0, 12'h0);
        step(1'b0, 1'b1, 1'b0, 12'h0);

        // Asynchronous reset mid-count
        step(1'b0, 1'b1, 1'b1, 12'h457);
        #3 rst_n = 1'b0;
        #1 check_reset_state("midrst");
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        en = 1'b1; up = 1'b1; load = 1'b0;
        #1 rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 12'h0);

        // Lower boundary then immediate direction reversal
        step(1'b0, 1'b1, 1'b1, 12'h000);
        step(1'b1, 1'b0, 1'b0, 12'h0);
        step(1'b1, 1'b1, 1'b0, 12'h0);
        step(1'b1, 1'b0, 1'b0, 12'h0);
        step(1'b1, 1'b0, 1'b0, 12'h0);

        // Mixed random traffic, including invalid loads
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 12'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
